data_mem_responder: RTL and testbench

Data-memory responder for the single-cycle MIPS datapath: the memory-side end of the CPU's active-low memory strobes (`mem_enable`, `mem_read`, `mem_write`) produced by the control decoder. It accepts one word read or write per request, models a configurable access latency with an FSM and down-counter, holds the CPU via `stall`, and returns read data with a one-cycle `ready` pulse. It sits between the datapath's ALU-address and write-data nets and the register write-back mux.

---
 rtl/data_mem_if.sv | 20 ++
 rtl/data_mem_responder.sv | 54 +++++
 tb/tb_data_mem_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: CPU-to-data-memory strobe, address and response bundle
interface data_mem_if;
    logic        mem_enable;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        stall;
    logic        err;
    modport master (
        output mem_enable, mem_read, mem_write, addr, wdata,
        input  rdata, ready, stall, err
    );
    modport slave (
        input  mem_enable, mem_read, mem_write, addr, wdata,
        output rdata, ready, stall, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word data memory with fixed access latency, stall and ready pulse
module data_mem_responder #(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input logic   clk,
    input logic   rst,
    data_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, next;
    logic [31:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] a_q;
    logic [31:0] wd_q, rdata_q;
    logic [2:0] cnt;
    logic wr_q, bad_q, req, bad, fire;
    assign req  = !bus.mem_enable;
    assign bad  = (bus.mem_read == bus.mem_write) || (bus.addr[1:0] != 2'b00);
    assign fire = (state == BUSY) && (cnt == 3'd0);
    always_ff @(posedge clk)
        state <= rst ? IDLE : next;
    always_comb
        next = state == IDLE ? (req ? BUSY : IDLE) :
               state == BUSY ? (cnt == 3'd0 ? DONE : BUSY) : IDLE;
    always_comb begin
        bus.stall = (state == BUSY) || (state == IDLE && req);
        bus.ready = state == DONE;
        bus.err   = (state == DONE) && bad_q;
        bus.rdata = rdata_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 3'd0;
            rdata_q <= 32'd0;
            bad_q   <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                cnt   <= 3'(LATENCY - 1);
                a_q   <= bus.addr[ADDR_W+1:2];
                wd_q  <= bus.wdata;
                wr_q  <= !bus.mem_write;
                bad_q <= bad;
            end else if (state == BUSY && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (fire && !wr_q && !bad_q)
                rdata_q <= mem[a_q];
        end
    end
    // array has no reset, so the commit is gated by rst to let reset win over completion
    always_ff @(posedge clk)
        if (!rst && fire && wr_q && !bad_q)
            mem[a_q] <= wd_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven checks plus reset and back-to-back sequences
module tb_data_mem_responder;
    localparam logic [2:0] RD = 3'b001, WR = 3'b010, IL0 = 3'b000, IL1 = 3'b011, NONE = 3'b111;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errs = 0;
    int checks = 0;
    always #5 clk = ~clk;
    data_mem_if b0();
    data_mem_if b1();
    data_mem_responder #(.ADDR_W(6), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    data_mem_responder #(.ADDR_W(6), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    typedef struct {
        logic [2:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        e;
    } vec_t;
    vec_t tv[14];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input bit i, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        if (i) begin
            {b1.mem_enable, b1.mem_read, b1.mem_write} = s;
            b1.addr = a;
            b1.wdata = d;
        end else begin
            {b0.mem_enable, b0.mem_read, b0.mem_write} = s;
            b0.addr = a;
            b0.wdata = d;
        end
    endtask
    // returns with time inside the DONE cycle; lat = cycles from request cycle to ready
    task automatic run(input bit i, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int stalls);
        @(negedge clk);
        drive(i, s, a, d);
        lat = -1;
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (i ? b1.ready : b0.ready) begin
                lat = c;
                break;
            end
            if (i ? b1.stall : b0.stall) stalls++;
            @(negedge clk);
            if (c == 0) drive(i, NONE, 32'hFFFF_FFF0, 32'h0BAD_0BAD);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int lat, stalls, n, seen;
        int rc[2];
        logic [31:0] rv[2];
        tv[0]  = '{WR,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tv[1]  = '{RD,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tv[2]  = '{WR,  32'h100, 32'h12345678, 32'hDEADBEEF, 1'b0};
        tv[3]  = '{RD,  32'h0,   32'h0,        32'h12345678, 1'b0};
        tv[4]  = '{RD,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tv[5]  = '{RD,  32'h13,  32'h0,        32'hDEADBEEF, 1'b1};
        tv[6]  = '{IL0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1};
        tv[7]  = '{IL1, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1};
        tv[8]  = '{RD,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tv[9]  = '{WR,  32'h20,  32'h11112222, 32'hDEADBEEF, 1'b0};
        tv[10] = '{WR,  32'hFC,  32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
        tv[11] = '{RD,  32'hFC,  32'h0,        32'hCAFEF00D, 1'b0};
        tv[12] = '{WR,  32'h22,  32'h99999999, 32'hCAFEF00D, 1'b1};
        tv[13] = '{RD,  32'h20,  32'h0,        32'h11112222, 1'b0};
        drive(0, NONE, 32'h0, 32'h0);
        drive(1, NONE, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", 32'(b0.ready), 32'd0);
        chk("reset_err", 32'(b0.err), 32'd0);
        chk("reset_stall", 32'(b0.stall), 32'd0);
        chk("reset_rdata", b0.rdata, 32'd0);
        chk("reset_rdata_l1", b1.rdata, 32'd0);
        for (int k = 0; k < 14; k++) begin
            run(0, tv[k].s, tv[k].a, tv[k].d, lat, stalls);
            chk($sformatf("v%0d_latency", k), lat, 3);
            chk($sformatf("v%0d_stall_cycles", k), stalls, 3);
            chk($sformatf("v%0d_rdata", k), b0.rdata, tv[k].rd);
            chk($sformatf("v%0d_err", k), 32'(b0.err), 32'(tv[k].e));
            chk($sformatf("v%0d_stall_in_done", k), 32'(b0.stall), 32'd0);
        end
        // reset in the first BUSY cycle abandons the write
        @(negedge clk);
        drive(0, WR, 32'h20, 32'hAAAA5555);
        @(negedge clk);
        rst = 1'b1;
        drive(0, NONE, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy_ready", 32'(b0.ready), 32'd0);
        chk("rst_busy_stall", 32'(b0.stall), 32'd0);
        chk("rst_busy_err", 32'(b0.err), 32'd0);
        chk("rst_busy_rdata", b0.rdata, 32'd0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (b0.ready) seen++;
        end
        chk("rst_busy_no_ready", seen, 0);
        run(0, RD, 32'h20, 32'h0, lat, stalls);
        chk("rst_busy_readback", b0.rdata, 32'h11112222);
        // reset coinciding with the completion edge
        @(negedge clk);
        drive(0, WR, 32'h20, 32'h5A5A5A5A);
        @(negedge clk);
        drive(0, NONE, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_done_ready", 32'(b0.ready), 32'd0);
        run(0, RD, 32'h20, 32'h0, lat, stalls);
        chk("rst_done_readback", b0.rdata, 32'h11112222);
        // LATENCY=1 instance: preload, then held back-to-back reads
        run(1, WR, 32'h8, 32'h00001111, lat, stalls);
        chk("l1_wr_latency", lat, 2);
        chk("l1_wr_stalls", stalls, 2);
        run(1, WR, 32'hC, 32'h22220000, lat, stalls);
        chk("l1_wr2_latency", lat, 2);
        @(negedge clk);
        drive(1, RD, 32'h8, 32'h0);
        n = 0;
        rc[0] = -1;
        rc[1] = -1;
        rv[0] = 32'h0;
        rv[1] = 32'h0;
        for (int c = 0; c < 12 && n < 2; c++) begin
            #1;
            if (b1.ready) begin
                rc[n] = c;
                rv[n] = b1.rdata;
                n++;
            end
            @(negedge clk);
            if (n == 1) b1.addr = 32'hC;
            if (n == 2) drive(1, NONE, 32'h0, 32'h0);
        end
        chk("l1_ready_count", n, 2);
        chk("l1_ready0_cycle", rc[0], 2);
        chk("l1_ready1_cycle", rc[1], 5);
        chk("l1_rdata0", rv[0], 32'h00001111);
        chk("l1_rdata1", rv[1], 32'h22220000);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
